// File: rtl/instr_queue_pkg.sv
// Shared instruction types for fetch, queue and dispatch.
// iq_entry_t is the packed queue payload reused by dispatch.
package instr_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [13:0] pc_t;

    typedef struct packed {
        word_t instr;
        pc_t   PC;
        pc_t   nPC;
    } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Instruction queue between fetch and dispatch: circular flop buffer
// with wrap-bit pointers, early fetch stall, flush and sticky overflow.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int IQ_DEPTH     = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        fetch_ivalid,
    input  word_t                       fetch_instr,
    input  pc_t                         fetch_PC,
    input  pc_t                         fetch_nPC,
    output logic                        fetch_stall,
    input  logic                        flush,
    output logic                        dispatch_valid,
    output word_t                       dispatch_instr,
    output pc_t                         dispatch_PC,
    output pc_t                         dispatch_nPC,
    input  logic                        dispatch_ready,
    output logic [$clog2(IQ_DEPTH):0]   iq_count,
    output logic                        iq_overflow
);

    localparam int AW = $clog2(IQ_DEPTH);

    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] STALL_TH =
        (AW+1)'(IQ_DEPTH - STALL_MARGIN);

    iq_entry_t   mem [IQ_DEPTH];
    logic [AW:0] head;
    logic [AW:0] tail;
    logic [AW:0] count;
    logic        ovf;

    logic        empty;
    logic        full;
    logic        deq;
    logic        enq;
    logic        ovf_set;
    iq_entry_t   head_e;
    iq_entry_t   in_e;

    assign empty = (head == tail);
    assign full  = (head[AW-1:0] == tail[AW-1:0]) &&
                   (head[AW] != tail[AW]);

    assign deq     = !empty && dispatch_ready && !flush;
    assign enq     = fetch_ivalid && !flush && (!full || deq);
    assign ovf_set = fetch_ivalid && !flush && full && !deq;

    assign in_e.instr = fetch_instr;
    assign in_e.PC    = fetch_PC;
    assign in_e.nPC   = fetch_nPC;

    // Head storage is registered; no enqueue-to-dispatch bypass.
    assign head_e = empty ? '0 : mem[head[AW-1:0]];

    assign dispatch_valid = !empty;
    assign dispatch_instr = head_e.instr;
    assign dispatch_PC    = head_e.PC;
    assign dispatch_nPC   = head_e.nPC;
    assign iq_count       = count;
    assign iq_overflow    = ovf;
    assign fetch_stall    = (count >= STALL_TH);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + ONE;
            if (deq) head <= head + ONE;
            unique case ({enq, deq})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq) begin
            mem[tail[AW-1:0]] <= in_e;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (IQ_DEPTH=8,
// STALL_MARGIN=2); inputs change on negedge, outputs checked there.
module tb_instr_queue;

    logic        CLK;
    logic        nRST;
    logic        fetch_ivalid;
    logic [31:0] fetch_instr;
    logic [13:0] fetch_PC;
    logic [13:0] fetch_nPC;
    logic        fetch_stall;
    logic        flush;
    logic        dispatch_valid;
    logic [31:0] dispatch_instr;
    logic [13:0] dispatch_PC;
    logic [13:0] dispatch_nPC;
    logic        dispatch_ready;
    logic [3:0]  iq_count;
    logic        iq_overflow;

    int n_cmp;
    int n_err;

    instr_queue #(
        .IQ_DEPTH     (8),
        .STALL_MARGIN (2)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .fetch_ivalid   (fetch_ivalid),
        .fetch_instr    (fetch_instr),
        .fetch_PC       (fetch_PC),
        .fetch_nPC      (fetch_nPC),
        .fetch_stall    (fetch_stall),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_instr (dispatch_instr),
        .dispatch_PC    (dispatch_PC),
        .dispatch_nPC   (dispatch_nPC),
        .dispatch_ready (dispatch_ready),
        .iq_count       (iq_count),
        .iq_overflow    (iq_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        fetch_ivalid   = 1'b0;
        fetch_instr    = '0;
        fetch_PC       = '0;
        fetch_nPC      = '0;
        flush          = 1'b0;
        dispatch_ready = 1'b0;
    endtask

    task automatic drive_fetch(input logic [13:0] pc);
        fetch_ivalid = 1'b1;
        fetch_instr  = {18'h0, pc} ^ 32'hA5A5_0000;
        fetch_PC     = pc;
        fetch_nPC    = pc + 14'd1;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({dispatch_valid, fetch_stall, iq_overflow} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000",
                     {dispatch_valid, fetch_stall, iq_overflow});
        end
        n_cmp++;
        if ({dispatch_instr, dispatch_PC, dispatch_nPC, iq_count} !== '0) begin
            n_err++;
            $display("FAIL reset_data: instr %h pc %h npc %h cnt %0d want 0",
                     dispatch_instr, dispatch_PC, dispatch_nPC, iq_count);
        end
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single();
        fetch_ivalid   = 1'b1;
        fetch_instr    = 32'h8C22_0004;
        fetch_PC       = 14'h0010;
        fetch_nPC      = 14'h0011;
        dispatch_ready = 1'b0;
        n_cmp++;
        if (dispatch_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_no_bypass: valid %b want 0", dispatch_valid);
        end
        @(negedge CLK);
        idle_inputs();
        n_cmp++;
        if (dispatch_valid !== 1'b1 || dispatch_instr !== 32'h8C22_0004) begin
            n_err++;
            $display("FAIL single_head: valid %b instr %h want 1 8c220004",
                     dispatch_valid, dispatch_instr);
        end
        n_cmp++;
        if (dispatch_PC !== 14'h0010 || dispatch_nPC !== 14'h0011 ||
            iq_count !== 4'd1) begin
            n_err++;
            $display("FAIL single_fields: pc %h npc %h cnt %0d want 10 11 1",
                     dispatch_PC, dispatch_nPC, iq_count);
        end
        dispatch_ready = 1'b1;
        @(negedge CLK);
        idle_inputs();
        n_cmp++;
        if (dispatch_valid !== 1'b0 || dispatch_instr !== 32'h0 ||
            iq_count !== 4'd0) begin
            n_err++;
            $display("FAIL single_drain: valid %b instr %h cnt %0d want 0 0 0",
                     dispatch_valid, dispatch_instr, iq_count);
        end
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 8; i++) begin
            drive_fetch(14'h0100 + 14'(i));
            dispatch_ready = 1'b0;
            @(negedge CLK);
            n_cmp++;
            if (iq_count !== 4'(i + 1) || fetch_stall !== (i + 1 >= 6)) begin
                n_err++;
                $display("FAIL fill_%0d: cnt %0d stall %b want %0d %b",
                         i, iq_count, fetch_stall, i + 1, (i + 1 >= 6));
            end
        end
        idle_inputs();
        n_cmp++;
        if (iq_overflow !== 1'b0 || dispatch_PC !== 14'h0100) begin
            n_err++;
            $display("FAIL fill_full: ovf %b pc %h want 0 100",
                     iq_overflow, dispatch_PC);
        end
    endtask

    task automatic test_full_simul();
        drive_fetch(14'h0200);
        dispatch_ready = 1'b1;
        @(negedge CLK);
        idle_inputs();
        n_cmp++;
        if (iq_count !== 4'd8 || dispatch_PC !== 14'h0101 ||
            iq_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_simul: cnt %0d pc %h ovf %b want 8 101 0",
                     iq_count, dispatch_PC, iq_overflow);
        end
    endtask

    task automatic test_overflow();
        drive_fetch(14'h0300);
        dispatch_ready = 1'b0;
        @(negedge CLK);
        idle_inputs();
        n_cmp++;
        if (iq_overflow !== 1'b1 || iq_count !== 4'd8 ||
            dispatch_PC !== 14'h0101) begin
            n_err++;
            $display("FAIL overflow: ovf %b cnt %0d pc %h want 1 8 101",
                     iq_overflow, iq_count, dispatch_PC);
        end
        // Drain and confirm wrapped tail entry and dropped entry absent
        for (int i = 0; i < 8; i++) begin
            logic [13:0] exp_pc;
            exp_pc = (i < 7) ? 14'h0101 + 14'(i) : 14'h0200;
            n_cmp++;
            if (dispatch_valid !== 1'b1 || dispatch_PC !== exp_pc) begin
                n_err++;
                $display("FAIL drain_%0d: valid %b pc %h want 1 %h",
                         i, dispatch_valid, dispatch_PC, exp_pc);
            end
            dispatch_ready = 1'b1;
            @(negedge CLK);
            idle_inputs();
        end
        n_cmp++;
        if (dispatch_valid !== 1'b0 || iq_count !== 4'd0) begin
            n_err++;
            $display("FAIL drain_empty: valid %b cnt %0d want 0 0",
                     dispatch_valid, iq_count);
        end
        flush = 1'b1;
        @(negedge CLK);
        idle_inputs();
        n_cmp++;
        if (iq_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf %b want 1", iq_overflow);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive_fetch(14'h0500 + 14'(i));
            @(negedge CLK);
        end
        idle_inputs();
        n_cmp++;
        if (iq_count !== 4'd5 || fetch_stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_pre: cnt %0d stall %b want 5 0",
                     iq_count, fetch_stall);
        end
        drive_fetch(14'h0555);
        dispatch_ready = 1'b1;
        flush          = 1'b1;
        @(negedge CLK);
        idle_inputs();
        n_cmp++;
        if (iq_count !== 4'd0 || dispatch_valid !== 1'b0 ||
            fetch_stall !== 1'b0 || dispatch_PC !== 14'h0) begin
            n_err++;
            $display("FAIL flush: cnt %0d valid %b stall %b pc %h want 0 0 0 0",
                     iq_count, dispatch_valid, fetch_stall, dispatch_PC);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive_fetch(14'h0400 + 14'(i));
            @(negedge CLK);
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (dispatch_PC !== 14'h0400 + 14'(i) || iq_count !== 4'd3) begin
                n_err++;
                $display("FAIL b2b_%0d: pc %h cnt %0d want %h 3",
                         i, dispatch_PC, iq_count, 14'h0400 + 14'(i));
            end
            drive_fetch(14'h0403 + 14'(i));
            dispatch_ready = 1'b1;
            @(negedge CLK);
        end
        idle_inputs();
        for (int i = 20; i < 23; i++) begin
            n_cmp++;
            if (dispatch_PC !== 14'h0400 + 14'(i) ||
                dispatch_nPC !== 14'h0401 + 14'(i)) begin
                n_err++;
                $display("FAIL b2b_tail_%0d: pc %h npc %h want %h",
                         i, dispatch_PC, dispatch_nPC, 14'h0400 + 14'(i));
            end
            dispatch_ready = 1'b1;
            @(negedge CLK);
            idle_inputs();
        end
        n_cmp++;
        if (dispatch_valid !== 1'b0 || iq_count !== 4'd0) begin
            n_err++;
            $display("FAIL b2b_empty: valid %b cnt %0d want 0 0",
                     dispatch_valid, iq_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            drive_fetch(14'h0600 + 14'(i));
            @(negedge CLK);
        end
        idle_inputs();
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (iq_count !== 4'd0 || dispatch_valid !== 1'b0 ||
            fetch_stall !== 1'b0 || iq_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: cnt %0d valid %b stall %b ovf %b",
                     iq_count, dispatch_valid, fetch_stall, iq_overflow);
        end
        @(negedge CLK);
        nRST = 1'b1;
        drive_fetch(14'h0700);
        @(negedge CLK);
        idle_inputs();
        n_cmp++;
        if (dispatch_PC !== 14'h0700 || iq_count !== 4'd1) begin
            n_err++;
            $display("FAIL reset_after: pc %h cnt %0d want 700 1",
                     dispatch_PC, iq_count);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_fill_stall();
        test_full_simul();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
